// File: rtl/axi_sdram_ax_arbiter_if.sv
// Address-channel bundle between the AXI AR/AW slave ports and the boundary-protect stage.
// The arbiter binds the slave modport; the environment driving it binds master.
interface axi_sdram_ax_arbiter_if;
  logic [53:0] s_ar_data;
  logic        s_ar_valid;
  logic        s_ar_ready;
  logic [53:0] s_aw_data;
  logic        s_aw_valid;
  logic        s_aw_ready;
  logic [53:0] m_ax_data;
  logic        m_ax_valid;
  logic        m_ax_ready;

  modport slave (
    input  s_ar_data,
    input  s_ar_valid,
    output s_ar_ready,
    input  s_aw_data,
    input  s_aw_valid,
    output s_aw_ready,
    output m_ax_data,
    output m_ax_valid,
    input  m_ax_ready
  );

  modport master (
    output s_ar_data,
    output s_ar_valid,
    input  s_ar_ready,
    output s_aw_data,
    output s_aw_valid,
    input  s_aw_ready,
    input  m_ax_data,
    input  m_ax_valid,
    output m_ax_ready
  );
endinterface

// File: rtl/axi_sdram_ax_arbiter.sv
// Merges AR and AW into one address stream, keeping a single direction in flight at a time
// and bounding the number of outstanding transactions of that direction.
module axi_sdram_ax_arbiter #(
  parameter logic [3:0] max_outstanding  = 4'd4,
  parameter real        simulation_delay = 1.0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axi_sdram_ax_arbiter_if.slave        bus,
  input  logic                         rd_trans_done,
  input  logic                         wr_trans_done,
  output logic                         cur_dir,
  output logic [3:0]                   outstanding_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OUT   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  // A limit of zero would deadlock the arbiter, so treat it as one.
  localparam logic [3:0] max_cnt = (max_outstanding == 4'd0) ? 4'd1 : max_outstanding;

  // Register updates are zero-delay; the delay value has no effect on hardware.
  if (simulation_delay < 0.0) begin : g_negative_delay_ignored
  end

  logic [1:0]  state_reg, state_next;
  logic        cur_dir_reg, cur_dir_next;
  logic        last_grant_reg, last_grant_next;
  logic        target_reg, target_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [53:0] data_reg, data_next;
  logic        live_reg;

  logic        grant;
  logic        grant_dir;
  logic [53:0] grant_data;
  logic        cnt_zero;
  logic        cnt_room;
  logic        ar_elig;
  logic        aw_elig;
  logic        cnt_inc;
  logic        cnt_dec;
  logic        done_cur;

  assign cnt_zero = (cnt_reg == 4'd0);
  assign cnt_room = (cnt_reg < max_cnt);

  // Same direction may stack up to the limit; switching direction needs an empty pipe.
  assign ar_elig = bus.s_ar_valid && (cnt_zero || ((cur_dir_reg == DIR_RD) && cnt_room));
  assign aw_elig = bus.s_aw_valid && (cnt_zero || ((cur_dir_reg == DIR_WR) && cnt_room));

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    grant       = 1'b0;
    grant_dir   = DIR_RD;
    case (state_reg)
      ST_IDLE: begin
        // live_reg keeps readies low on the first cycle after reset release.
        if (live_reg) begin
          if (bus.s_ar_valid && bus.s_aw_valid) begin
            grant_dir = ~last_grant_reg;
            if (grant_dir == DIR_WR ? aw_elig : ar_elig) begin
              grant = 1'b1;
            end else begin
              state_next  = ST_DRAIN;
              target_next = grant_dir;
            end
          end else if (ar_elig) begin
            grant     = 1'b1;
            grant_dir = DIR_RD;
          end else if (aw_elig) begin
            grant     = 1'b1;
            grant_dir = DIR_WR;
          end else if (bus.s_ar_valid && (cur_dir_reg != DIR_RD)) begin
            state_next  = ST_DRAIN;
            target_next = DIR_RD;
          end else if (bus.s_aw_valid && (cur_dir_reg != DIR_WR)) begin
            state_next  = ST_DRAIN;
            target_next = DIR_WR;
          end
        end
      end
      ST_OUT: begin
        if (bus.m_ax_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          grant_dir = target_reg;
          if (target_reg == DIR_WR ? bus.s_aw_valid : bus.s_ar_valid) begin
            grant = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (grant) begin
      state_next = ST_OUT;
    end
  end

  assign grant_data = (grant_dir == DIR_WR) ? bus.s_aw_data : bus.s_ar_data;

  // Bit 53 is reserved upstream and is replaced by the direction flag downstream.
  always_comb begin
    data_next       = data_reg;
    cur_dir_next    = cur_dir_reg;
    last_grant_next = last_grant_reg;
    if (grant) begin
      data_next       = grant_data;
      data_next[53]   = grant_dir;
      cur_dir_next    = grant_dir;
      last_grant_next = grant_dir;
    end
  end

  assign done_cur = (cur_dir_reg == DIR_WR) ? wr_trans_done : rd_trans_done;
  assign cnt_inc  = (state_reg == ST_OUT) && bus.m_ax_ready && (cnt_reg != max_cnt);
  assign cnt_dec  = done_cur && !cnt_zero;

  always_comb begin
    cnt_next = cnt_reg;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_next = cnt_reg + 4'd1;
      2'b01:   cnt_next = cnt_reg - 4'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cur_dir_reg    <= DIR_RD;
      last_grant_reg <= DIR_WR;
      target_reg     <= DIR_RD;
      cnt_reg        <= 4'd0;
      data_reg       <= 54'd0;
      live_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_dir_reg    <= cur_dir_next;
      last_grant_reg <= last_grant_next;
      target_reg     <= target_next;
      cnt_reg        <= cnt_next;
      data_reg       <= data_next;
      live_reg       <= 1'b1;
    end
  end

  assign bus.s_ar_ready  = grant && (grant_dir == DIR_RD);
  assign bus.s_aw_ready  = grant && (grant_dir == DIR_WR);
  assign bus.m_ax_valid  = (state_reg == ST_OUT);
  assign bus.m_ax_data   = data_reg;
  assign cur_dir         = cur_dir_reg;
  assign outstanding_cnt = cnt_reg;

endmodule

// File: tb/tb_axi_sdram_ax_arbiter.sv
// Directed cycle table plus hand sequences for the limit, drain and async-reset corners.
module tb_axi_sdram_ax_arbiter;

  localparam logic [53:0] AR_D   = 54'h3F0123456789AB;
  localparam logic [53:0] AR_OUT = 54'h1F0123456789AB;
  localparam logic [53:0] AW_D   = 54'h0A5A5A5A5A5A5A;
  localparam logic [53:0] AW_OUT = 54'h2A5A5A5A5A5A5A;
  localparam logic [53:0] ZD     = 54'd0;

  typedef struct {
    logic [4:0]  stim;   // {ar_valid, aw_valid, m_ax_ready, rd_done, wr_done}
    logic [2:0]  e_hs;   // {s_ar_ready, s_aw_ready, m_ax_valid}
    logic [3:0]  e_cnt;
    logic        e_dir;
    logic [53:0] e_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_trans_done = 1'b0;
  logic       wr_trans_done = 1'b0;
  logic       cur_dir;
  logic [3:0] outstanding_cnt;

  int tests = 0;
  int fails = 0;
  int remaining = 0;
  int grants = 0;

  vec_t vecs [26];

  axi_sdram_ax_arbiter_if bus ();

  axi_sdram_ax_arbiter #(
    .max_outstanding (4'd4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .rd_trans_done   (rd_trans_done),
    .wr_trans_done   (wr_trans_done),
    .cur_dir         (cur_dir),
    .outstanding_cnt (outstanding_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] stim, input logic [2:0] e_hs,
                              input logic [3:0] e_cnt, input logic e_dir, input logic [53:0] e_data);
    vec_t v;
    v.stim   = stim;
    v.e_hs   = e_hs;
    v.e_cnt  = e_cnt;
    v.e_dir  = e_dir;
    v.e_data = e_data;
    return v;
  endfunction

  // Continuous invariants: one ready at a time, counter never above the limit.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_exclusive", 0, 64'(bus.s_ar_ready & bus.s_aw_ready), 64'(1'b0));
      chk("cnt_le_max", 0, 64'(outstanding_cnt > 4'd4), 64'(1'b0));
    end
  end

  task automatic run_aw(input int n, input bit pulse_wr);
    for (int i = 0; i < n; i++) begin
      bus.s_aw_valid = (remaining > 0);
      wr_trans_done  = pulse_wr && (i == 0);
      @(negedge clk);
      if (bus.s_aw_ready && bus.s_aw_valid) begin
        grants++;
        remaining--;
        $display("[TB] aw grant %0d cnt=%0d", grants, outstanding_cnt);
      end
      @(posedge clk);
      #1;
    end
    wr_trans_done = 1'b0;
  endtask

  initial begin
    logic got;

    vecs[0]  = mk(5'b11100, 3'b000, 4'd0, 1'b0, ZD);
    vecs[1]  = mk(5'b11100, 3'b100, 4'd0, 1'b0, ZD);
    vecs[2]  = mk(5'b01100, 3'b001, 4'd0, 1'b0, AR_OUT);
    vecs[3]  = mk(5'b01100, 3'b000, 4'd1, 1'b0, AR_OUT);
    vecs[4]  = mk(5'b01100, 3'b000, 4'd1, 1'b0, AR_OUT);
    vecs[5]  = mk(5'b01110, 3'b000, 4'd1, 1'b0, AR_OUT);
    vecs[6]  = mk(5'b01100, 3'b010, 4'd0, 1'b0, AR_OUT);
    vecs[7]  = mk(5'b00000, 3'b001, 4'd0, 1'b1, AW_OUT);
    vecs[8]  = mk(5'b00000, 3'b001, 4'd0, 1'b1, AW_OUT);
    vecs[9]  = mk(5'b00000, 3'b001, 4'd0, 1'b1, AW_OUT);
    vecs[10] = mk(5'b00000, 3'b001, 4'd0, 1'b1, AW_OUT);
    vecs[11] = mk(5'b00000, 3'b001, 4'd0, 1'b1, AW_OUT);
    vecs[12] = mk(5'b00100, 3'b001, 4'd0, 1'b1, AW_OUT);
    vecs[13] = mk(5'b00101, 3'b000, 4'd1, 1'b1, AW_OUT);
    vecs[14] = mk(5'b00110, 3'b000, 4'd0, 1'b1, AW_OUT);
    vecs[15] = mk(5'b10100, 3'b100, 4'd0, 1'b1, AW_OUT);
    vecs[16] = mk(5'b00100, 3'b001, 4'd0, 1'b0, AR_OUT);
    vecs[17] = mk(5'b10100, 3'b100, 4'd1, 1'b0, AR_OUT);
    vecs[18] = mk(5'b00101, 3'b001, 4'd1, 1'b0, AR_OUT);
    vecs[19] = mk(5'b10100, 3'b100, 4'd2, 1'b0, AR_OUT);
    vecs[20] = mk(5'b00110, 3'b001, 4'd2, 1'b0, AR_OUT);
    vecs[21] = mk(5'b00100, 3'b000, 4'd2, 1'b0, AR_OUT);
    vecs[22] = mk(5'b00110, 3'b000, 4'd2, 1'b0, AR_OUT);
    vecs[23] = mk(5'b00110, 3'b000, 4'd1, 1'b0, AR_OUT);
    vecs[24] = mk(5'b00110, 3'b000, 4'd0, 1'b0, AR_OUT);
    vecs[25] = mk(5'b00100, 3'b000, 4'd0, 1'b0, AR_OUT);

    bus.s_ar_data  = AR_D;
    bus.s_aw_data  = AW_D;
    bus.s_ar_valid = 1'b1;
    bus.s_aw_valid = 1'b1;
    bus.m_ax_ready = 1'b1;

    // Outputs held in reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", 0, 64'(bus.s_ar_ready), 64'(1'b0));
    chk("rst_aw_ready", 0, 64'(bus.s_aw_ready), 64'(1'b0));
    chk("rst_m_valid", 0, 64'(bus.m_ax_valid), 64'(1'b0));
    chk("rst_data", 0, 64'(bus.m_ax_data), 64'(ZD));
    chk("rst_cnt", 0, 64'(outstanding_cnt), 64'(4'd0));
    chk("rst_dir", 0, 64'(cur_dir), 64'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      {bus.s_ar_valid, bus.s_aw_valid, bus.m_ax_ready, rd_trans_done, wr_trans_done} = vecs[i].stim;
      @(negedge clk);
      $display("[TB] vec %0d ar_rdy=%0b aw_rdy=%0b m_valid=%0b cnt=%0d dir=%0b data=%h",
               i, bus.s_ar_ready, bus.s_aw_ready, bus.m_ax_valid, outstanding_cnt, cur_dir, bus.m_ax_data);
      chk("ar_ready", i, 64'(bus.s_ar_ready), 64'(vecs[i].e_hs[2]));
      chk("aw_ready", i, 64'(bus.s_aw_ready), 64'(vecs[i].e_hs[1]));
      chk("m_valid", i, 64'(bus.m_ax_valid), 64'(vecs[i].e_hs[0]));
      chk("cnt", i, 64'(outstanding_cnt), 64'(vecs[i].e_cnt));
      chk("cur_dir", i, 64'(cur_dir), 64'(vecs[i].e_dir));
      chk("m_data", i, 64'(bus.m_ax_data), 64'(vecs[i].e_data));
      @(posedge clk);
      #1;
    end
    {bus.s_ar_valid, bus.s_aw_valid, rd_trans_done, wr_trans_done} = 4'b0000;
    bus.m_ax_ready = 1'b1;

    // Six back-to-back writes against a limit of four.
    remaining = 6;
    grants = 0;
    run_aw(12, 1'b0);
    chk("limit_grants", 0, 64'(grants), 64'(4));
    chk("limit_cnt", 0, 64'(outstanding_cnt), 64'(4'd4));
    chk("limit_dir", 0, 64'(cur_dir), 64'(1'b1));
    run_aw(8, 1'b1);
    chk("limit_one_more", 0, 64'(grants), 64'(5));
    chk("limit_cnt_back", 0, 64'(outstanding_cnt), 64'(4'd4));

    remaining = 0;
    bus.s_aw_valid = 1'b0;
    wr_trans_done = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wr_trans_done = 1'b0;
    @(negedge clk);
    chk("drain_cnt", 0, 64'(outstanding_cnt), 64'(4'd0));
    @(posedge clk);
    #1;

    // Build cnt = 3, then park a fourth write in OUT and reset underneath it.
    remaining = 3;
    run_aw(6, 1'b0);
    bus.m_ax_ready = 1'b0;
    remaining = 1;
    run_aw(3, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 0, 64'(bus.m_ax_valid), 64'(1'b1));
    chk("pre_rst_cnt", 0, 64'(outstanding_cnt), 64'(4'd3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, 64'(bus.m_ax_valid), 64'(1'b0));
    chk("async_rst_cnt", 0, 64'(outstanding_cnt), 64'(4'd0));
    chk("async_rst_dir", 0, 64'(cur_dir), 64'(1'b0));
    chk("async_rst_data", 0, 64'(bus.m_ax_data), 64'(ZD));
    bus.s_aw_valid = 1'b0;
    bus.s_ar_valid = 1'b1;
    bus.m_ax_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_first_ready", 0, 64'(bus.s_ar_ready), 64'(1'b0));
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.s_ar_ready) got = 1'b1;
    end
    chk("post_rst_ar_accept", 0, 64'(got), 64'(1'b1));
    @(posedge clk);
    #1;
    bus.s_ar_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 0, 64'(bus.m_ax_valid), 64'(1'b1));
    chk("post_rst_data", 0, 64'(bus.m_ax_data), 64'(AR_OUT));
    chk("post_rst_dir", 0, 64'(cur_dir), 64'(1'b0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_cnt", 0, 64'(outstanding_cnt), 64'(4'd1));
    chk("post_rst_idle", 0, 64'(bus.m_ax_valid), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
